// File: rtl/cg_timer_sched_pkg.sv
// Shared types for the shared round-robin interval timer.
// State encoding and owner-index width helper.
package cg_timer_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cg_timer_sched_if.sv
// Request/grant bundle of the shared interval timer.
// CG_TIMER_SCHED_PRESCALE_EN adds the i_tick advance strobe.
interface cg_timer_sched_if
  import cg_timer_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);

  localparam int OW = owner_w(NUM_REQ);

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_len;
  logic                          i_abort;
  logic [NUM_REQ-1:0]            o_gnt;
  logic [NUM_REQ-1:0]            o_done;
  logic                          o_busy;
  logic [OW-1:0]                 o_owner;
  logic [DATA_WIDTH-1:0]         o_count;

`ifdef CG_TIMER_SCHED_PRESCALE_EN
  logic i_tick;

  modport master (
    output i_req, i_len, i_abort, i_tick,
    input  o_gnt, o_done, o_busy, o_owner, o_count
  );

  modport slave (
    input  i_req, i_len, i_abort, i_tick,
    output o_gnt, o_done, o_busy, o_owner, o_count
  );
`else
  modport master (
    output i_req, i_len, i_abort,
    input  o_gnt, o_done, o_busy, o_owner, o_count
  );

  modport slave (
    input  i_req, i_len, i_abort,
    output o_gnt, o_done, o_busy, o_owner, o_count
  );
`endif

endinterface

// File: rtl/cg_timer_sched_counter.sv
// Elapsed-count register: preset wins over stop,
// otherwise counts up by one per enabled cycle.
module cg_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_default,
  input  logic             i_prst,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_prst) begin
      o_count <= i_default;
    end else if (!i_stop) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cg_timer_sched.sv
// Round-robin shared interval timer: IDLE/LOAD/RUN/DONE.
// CG_TIMER_SCHED_PRESCALE_EN gates RUN advances with i_tick.
module cg_timer_sched
  import cg_timer_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  cg_timer_sched_if.slave  bus
);

  localparam int OW = owner_w(NUM_REQ);
  localparam logic [OW-1:0] PTR_RST = OW'(NUM_REQ - 1);

  state_t                state;
  state_t                nstate;
  logic [OW-1:0]         owner;
  logic [OW-1:0]         ptr;
  logic [OW-1:0]         win;
  logic                  hit;
  logic [DATA_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0] count;
  logic                  adv;
  logic                  last;
  logic                  stop;

`ifdef CG_TIMER_SCHED_PRESCALE_EN
  assign adv = bus.i_tick;
`else
  assign adv = 1'b1;
`endif

  assign last = (count == len_q - DATA_WIDTH'(1));

  // Search starts one past the previous winner.
  always_comb begin
    win = ptr;
    hit = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!hit && bus.i_req[(int'(ptr) + i) % NUM_REQ]) begin
        hit = 1'b1;
        win = OW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE: begin
        if (hit) nstate = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.i_abort)        nstate = ST_IDLE;
        else if (len_q == '0)   nstate = ST_DONE;
        else                    nstate = ST_RUN;
      end
      ST_RUN: begin
        if (bus.i_abort)        nstate = ST_IDLE;
        else if (adv && last)   nstate = ST_DONE;
      end
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= PTR_RST;
      len_q <= '0;
    end else begin
      state <= nstate;
      if (state == ST_IDLE && hit) begin
        owner <= win;
        len_q <= bus.i_len[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == ST_DONE ||
          ((state == ST_LOAD || state == ST_RUN) && bus.i_abort)) begin
        ptr <= owner;
      end
    end
  end

  // The final advance leaves count at len-1 rather than len.
  assign stop = !(state == ST_RUN && adv) || last || bus.i_abort;

  cg_counter #(
    .WIDTH (DATA_WIDTH)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_default ({DATA_WIDTH{1'b0}}),
    .i_prst    (state == ST_LOAD),
    .i_stop    (stop),
    .o_count   (count)
  );

  always_comb begin
    bus.o_gnt  = '0;
    bus.o_done = '0;
    if (state == ST_LOAD) bus.o_gnt[owner]  = 1'b1;
    if (state == ST_DONE) bus.o_done[owner] = 1'b1;
  end

  assign bus.o_busy  = (state != ST_IDLE);
  assign bus.o_owner = owner;
  assign bus.o_count = count;

endmodule
